// File: rtl/write_resp_order.sv
// Write-response reorder buffer: tracks outstanding AW transactions in
// acceptance order and returns B responses upstream in that same order.
// Downstream B responses may arrive in any order and are parked in the queue.
module write_resp_order #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned RESP_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       aw_fire,
  input  logic [ID_W-1:0]            aw_id,
  output logic                       aw_allow,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  input  logic [ID_W-1:0]            m_bid,
  input  logic [RESP_W-1:0]          m_bresp,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  output logic [ID_W-1:0]            s_bid,
  output logic [RESP_W-1:0]          s_bresp,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       err_unexpected
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StEmpty, StActive, StFull} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [ID_W-1:0]   id_q   [DEPTH];
  logic [ID_W-1:0]   id_d   [DEPTH];
  logic [RESP_W-1:0] resp_q [DEPTH];
  logic [RESP_W-1:0] resp_d [DEPTH];
  logic              m_bready_q;
  logic              err_q;

  logic              alloc, b_acc, head_done, pop;
  logic              match_found;
  logic [PW-1:0]     match_idx;
  logic [PW-1:0]     idx;

  // aw_allow comes straight from the state register, so a pop in FULL
  // reopens the AW channel only on the following cycle.
  assign aw_allow       = (state_q != StFull);
  assign m_bready       = m_bready_q;
  assign err_unexpected = err_q;
  assign occupancy      = count_q;

  assign alloc     = aw_fire & aw_allow;
  assign b_acc     = m_bvalid & m_bready_q;
  assign head_done = valid_q[rd_ptr_q] & done_q[rd_ptr_q];
  assign pop       = head_done & s_bready;

  assign s_bvalid = head_done;
  assign s_bid    = head_done ? id_q[rd_ptr_q]   : '0;
  assign s_bresp  = head_done ? resp_q[rd_ptr_q] : '0;

  // Oldest-first search for a pending entry with a matching id; scanning
  // starts at the head so the first hit is the oldest outstanding AW.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    idx         = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (!match_found && valid_q[idx] && !done_q[idx] && (id_q[idx] == m_bid)) begin
        match_found = 1'b1;
        match_idx   = idx;
      end
    end
  end

  // Occupancy FSM next state: count and state move together.
  always_comb begin
    count_d = count_q;
    unique case ({alloc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (count_d == '0) begin
      state_d = StEmpty;
    end else if (count_d == CW'(DEPTH)) begin
      state_d = StFull;
    end else begin
      state_d = StActive;
    end
  end

  // Queue entry and pointer next state. Pop, allocate and mark always hit
  // distinct slots: the head is already done, and the write slot is free.
  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    id_d     = id_q;
    resp_d   = resp_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      done_d[rd_ptr_q]  = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (alloc) begin
      valid_d[wr_ptr_q] = 1'b1;
      done_d[wr_ptr_q]  = 1'b0;
      id_d[wr_ptr_q]    = aw_id;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (b_acc && match_found) begin
      done_d[match_idx] = 1'b1;
      resp_d[match_idx] = m_bresp;
    end
  end

  // State registers; reset drops every pending entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      id_q       <= '{default: '0};
      resp_q     <= '{default: '0};
      m_bready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      id_q       <= id_d;
      resp_q     <= resp_d;
      m_bready_q <= 1'b1;
      err_q      <= b_acc & ~match_found;
    end
  end

endmodule

// File: tb/tb_write_resp_order.sv
// Bench for write_resp_order: directed scenarios, a queue-based reference
// model compared every cycle, and literal checks on the observed B stream.
module tb_write_resp_order;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned RESP_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              aw_fire = 1'b0;
  logic [ID_W-1:0]   aw_id = '0;
  logic              aw_allow;
  logic              m_bvalid = 1'b0;
  logic              m_bready;
  logic [ID_W-1:0]   m_bid = '0;
  logic [RESP_W-1:0] m_bresp = '0;
  logic              s_bvalid;
  logic              s_bready = 1'b0;
  logic [ID_W-1:0]   s_bid;
  logic [RESP_W-1:0] s_bresp;
  logic [3:0]        occupancy;
  logic              err_unexpected;

  write_resp_order #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W),
    .RESP_W(RESP_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .aw_fire       (aw_fire),
    .aw_id         (aw_id),
    .aw_allow      (aw_allow),
    .m_bvalid      (m_bvalid),
    .m_bready      (m_bready),
    .m_bid         (m_bid),
    .m_bresp       (m_bresp),
    .s_bvalid      (s_bvalid),
    .s_bready      (s_bready),
    .s_bid         (s_bid),
    .s_bresp       (s_bresp),
    .occupancy     (occupancy),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of outstanding writes in acceptance order.
  typedef struct {
    logic [ID_W-1:0]   id;
    logic              done;
    logic [RESP_W-1:0] resp;
  } ent_t;

  ent_t mq[$];
  bit   mready = 1'b0;
  bit   merr   = 1'b0;
  bit   acc, hit, do_pop, do_alloc;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      mready = 1'b0;
      merr   = 1'b0;
    end else begin
      acc      = m_bvalid && mready;
      do_pop   = (mq.size() > 0) && mq[0].done && s_bready;
      do_alloc = aw_fire && (mq.size() < DEPTH);
      hit      = 1'b0;
      if (acc) begin
        foreach (mq[k]) begin
          if (!hit && !mq[k].done && mq[k].id == m_bid) begin
            mq[k].done = 1'b1;
            mq[k].resp = m_bresp;
            hit        = 1'b1;
          end
        end
      end
      merr = acc && !hit;
      if (do_pop) void'(mq.pop_front());
      if (do_alloc) mq.push_back('{id: aw_id, done: 1'b0, resp: '0});
      mready = 1'b1;
    end
  end

  // Observed upstream B stream, {id, resp}.
  logic [5:0] blog[$];

  // Per-cycle compare on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      logic              ev;
      logic [ID_W-1:0]   eid;
      logic [RESP_W-1:0] ersp;
      ev   = (mq.size() > 0) && mq[0].done;
      eid  = ev ? mq[0].id : '0;
      ersp = ev ? mq[0].resp : '0;
      chk("s_bvalid", 32'(s_bvalid), 32'(ev));
      chk("s_bid", 32'(s_bid), 32'(eid));
      chk("s_bresp", 32'(s_bresp), 32'(ersp));
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("aw_allow", 32'(aw_allow), 32'(mq.size() < DEPTH));
      chk("m_bready", 32'(m_bready), 32'(mready));
      chk("err_unexpected", 32'(err_unexpected), 32'(merr));
      if (s_bvalid === 1'b1 && s_bready === 1'b1) blog.push_back({s_bid, s_bresp});
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic cyc(input logic af, input logic [ID_W-1:0] ai, input logic bv,
                     input logic [ID_W-1:0] bi, input logic [RESP_W-1:0] br,
                     input logic sr);
    aw_fire  = af;
    aw_id    = ai;
    m_bvalid = bv;
    m_bid    = bi;
    m_bresp  = br;
    s_bready = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic sr);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, '0, sr);
  endtask

  task automatic chk_log(input string name, input int idx, input logic [5:0] exp);
    if (blog.size() > idx) chk(name, 32'(blog[idx]), 32'(exp));
    else chk({name, "_missing"}, 32'(blog.size()), 32'(idx + 1));
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_m_bready", 32'(m_bready), 32'd0);
    chk("rst_aw_allow", 32'(aw_allow), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("pre_edge_m_bready", 32'(m_bready), 32'd0);
    idle(1, 1'b1);
    chk("post_edge_m_bready", 32'(m_bready), 32'd1);

    // Out-of-order B ids 3,2,1 returned upstream as 1,2,3.
    blog.delete();
    cyc(1'b1, 4'd1, 1'b0, '0, '0, 1'b1);
    cyc(1'b1, 4'd2, 1'b0, '0, '0, 1'b1);
    cyc(1'b1, 4'd3, 1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1, 4'd3, 2'd0, 1'b1);
    cyc(1'b0, '0, 1'b1, 4'd2, 2'd1, 1'b1);
    chk("ooo_wait_head", 32'(s_bvalid), 32'd0);
    cyc(1'b0, '0, 1'b1, 4'd1, 2'd2, 1'b1);
    chk("ooo_first_valid", 32'(s_bvalid), 32'd1);
    chk("ooo_first_id", 32'(s_bid), 32'd1);
    idle(4, 1'b1);
    chk("ooo_count", 32'(blog.size()), 32'd3);
    chk_log("ooo_b0", 0, {4'd1, 2'd2});
    chk_log("ooo_b1", 1, {4'd2, 2'd1});
    chk_log("ooo_b2", 2, {4'd3, 2'd0});

    // Fill to FULL, extra AW ignored, one pop reopens aw_allow next cycle.
    blog.delete();
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'd5, 1'b0, '0, '0, 1'b0);
    chk("full_aw_allow", 32'(aw_allow), 32'd0);
    chk("full_occ", 32'(occupancy), 32'd8);
    cyc(1'b1, 4'd9, 1'b0, '0, '0, 1'b0);
    chk("full_ignore_occ", 32'(occupancy), 32'd8);
    cyc(1'b0, '0, 1'b1, 4'd5, 2'd3, 1'b0);
    chk("full_head_valid", 32'(s_bvalid), 32'd1);
    chk("full_still_closed", 32'(aw_allow), 32'd0);
    cyc(1'b0, '0, 1'b0, '0, '0, 1'b1);
    chk("pop_aw_allow", 32'(aw_allow), 32'd1);
    chk("pop_occ", 32'(occupancy), 32'd7);
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1, 4'd5, 2'd1, 1'b1);
    idle(3, 1'b1);
    chk("drain_occ", 32'(occupancy), 32'd0);
    chk("drain_count", 32'(blog.size()), 32'd8);

    // Same id twice: responses bind to the oldest pending entry.
    blog.delete();
    cyc(1'b1, 4'd4, 1'b0, '0, '0, 1'b1);
    cyc(1'b1, 4'd4, 1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1, 4'd4, 2'd2, 1'b1);
    cyc(1'b0, '0, 1'b1, 4'd4, 2'd0, 1'b1);
    idle(3, 1'b1);
    chk_log("dup_b0", 0, {4'd4, 2'd2});
    chk_log("dup_b1", 1, {4'd4, 2'd0});

    // Unexpected B id 9 with only id 7 pending.
    cyc(1'b1, 4'd7, 1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1, 4'd9, 2'd1, 1'b1);
    chk("unexp_pulse", 32'(err_unexpected), 32'd1);
    chk("unexp_occ", 32'(occupancy), 32'd1);
    chk("unexp_valid", 32'(s_bvalid), 32'd0);
    idle(1, 1'b1);
    chk("unexp_pulse_end", 32'(err_unexpected), 32'd0);
    cyc(1'b0, '0, 1'b1, 4'd7, 2'd0, 1'b1);
    idle(2, 1'b1);

    // Upstream back-pressure: head held stable, later responses buffered.
    blog.delete();
    cyc(1'b1, 4'd1, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 4'd2, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 4'd3, 1'b0, '0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, 4'd1, 2'd1, 1'b0);
    cyc(1'b0, '0, 1'b1, 4'd2, 2'd2, 1'b0);
    cyc(1'b0, '0, 1'b1, 4'd3, 2'd3, 1'b0);
    idle(3, 1'b0);
    chk("hold_id", 32'(s_bid), 32'd1);
    chk("hold_resp", 32'(s_bresp), 32'd1);
    chk("hold_none_out", 32'(blog.size()), 32'd0);
    idle(4, 1'b1);
    chk_log("bp_b0", 0, {4'd1, 2'd1});
    chk_log("bp_b1", 1, {4'd2, 2'd2});
    chk_log("bp_b2", 2, {4'd3, 2'd3});

    // Reset with three completed entries pending.
    blog.delete();
    cyc(1'b1, 4'd1, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 4'd2, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 4'd3, 1'b0, '0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, 4'd1, 2'd1, 1'b0);
    cyc(1'b0, '0, 1'b1, 4'd2, 2'd1, 1'b0);
    cyc(1'b0, '0, 1'b1, 4'd3, 2'd1, 1'b0);
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(s_bvalid), 32'd0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_bready", 32'(m_bready), 32'd0);
    idle(2, 1'b1);
    rst_n = 1'b1;
    idle(5, 1'b1);
    chk("post_rst_no_stale", 32'(blog.size()), 32'd0);
    chk("post_rst_bready", 32'(m_bready), 32'd1);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/write_resp_order.md
WRITE_RESP_ORDER -- requirements
Module: write_resp_order

Interface
REQ-001 Parameter DEPTH, default 8, number of outstanding write transactions tracked; power of two, >= 2.
REQ-002 Parameter ID_W, default 4, width of AW and B transaction IDs.
REQ-003 Parameter RESP_W, default 2, width of the B response code.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 aw_fire  input  1  AW handshake occurred on the master-side address channel this cycle.
REQ-007 aw_id  input  ID_W  AWID of the AW handshake.
REQ-008 aw_allow  output  1  high when a new AW may be accepted; the integrator ANDs it into awready.
REQ-009 m_bvalid  input  1  B response valid from downstream slave.
REQ-010 m_bready  output  1  B ready toward downstream slave.
REQ-011 m_bid  input  ID_W  downstream BID.
REQ-012 m_bresp  input  RESP_W  downstream BRESP.
REQ-013 s_bvalid  output  1  in-order B response valid toward upstream master.
REQ-014 s_bready  input  1  upstream master ready for B.
REQ-015 s_bid  output  ID_W  BID returned upstream.
REQ-016 s_bresp  output  RESP_W  BRESP returned upstream.
REQ-017 occupancy  output  $clog2(DEPTH)+1  number of allocated entries.
REQ-018 err_unexpected  output  1  one-cycle pulse: accepted B matched no pending entry.

Function
REQ-019 Block SHALL hold a circular queue of DEPTH entries {valid, done, id, resp} with wr_ptr, rd_ptr of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-020 Occupancy FSM SHALL have states EMPTY (count 0), ACTIVE (0 < count < DEPTH), FULL (count = DEPTH); state and count update on the same edge.
REQ-021 aw_allow SHALL be registered and equal to (state != FULL); a pop in FULL raises aw_allow one cycle later, not combinationally.
REQ-022 aw_fire while aw_allow high SHALL write {valid=1, done=0, id=aw_id} at wr_ptr and increment wr_ptr; aw_fire while aw_allow low SHALL be ignored (protocol violation, no state change).
REQ-023 m_bready SHALL be 1 in every cycle outside reset; B is never back-pressured downstream.
REQ-024 On m_bvalid, the block SHALL search from rd_ptr toward wr_ptr and mark the oldest entry with valid=1, done=0, id=m_bid as done=1, storing m_bresp; visible next cycle.
REQ-025 If no entry matches, the B SHALL be dropped and err_unexpected pulsed high for exactly one cycle (the cycle after acceptance).
REQ-026 An entry allocated by aw_fire in cycle N SHALL NOT be matchable by a B in cycle N; matchable from cycle N+1.
REQ-027 s_bvalid SHALL be high exactly when the entry at rd_ptr has valid=1 and done=1; s_bid/s_bresp SHALL present that entry's id/resp, stable while s_bvalid and not s_bready.
REQ-028 On s_bvalid and s_bready, the head entry SHALL be cleared (valid=0, done=0) and rd_ptr incremented.
REQ-029 Minimum latency m_bvalid (head entry) -> s_bvalid SHALL be 1 cycle; back-to-back pops at one per cycle SHALL be supported.
REQ-030 Simultaneous allocate and pop SHALL leave count unchanged; simultaneous B-mark and pop on different entries SHALL both take effect.
REQ-031 Responses for non-head entries SHALL be buffered until all older entries have been returned, so upstream B order equals AW acceptance order.
REQ-032 s_bid/s_bresp SHALL be 0 when s_bvalid is low.

Reset
REQ-033 While rst_n low: all entries valid=0/done=0, pointers 0, count 0, state EMPTY, aw_allow=1, m_bready=0, s_bvalid=0, s_bid=0, s_bresp=0, err_unexpected=0.
REQ-034 Reset asserted mid-operation SHALL discard all pending entries immediately; no B SHALL be emitted for them after release.
REQ-035 m_bready SHALL rise on the first clock edge after rst_n deasserts.

Verification
REQ-036 AW ids 1,2,3; B ids 3,2,1 one per cycle with resp 0,1,2 -> upstream B ids 1,2,3 with resp 2,1,0, back-to-back, first s_bvalid 1 cycle after B id 1.
REQ-037 8 AW with id 5, no B -> aw_allow 0 the cycle after 8th aw_fire, occupancy 8; pop one -> aw_allow 1 one cycle later.
REQ-038 Two AW id 4 then B id 4 resp 2, B id 4 resp 0 -> upstream resp 2 then 0 (oldest-match rule).
REQ-039 B id 9 with no pending id 9 -> err_unexpected single pulse, occupancy and s_bvalid unchanged.
REQ-040 s_bready held low 5 cycles with s_bvalid high -> s_bid/s_bresp stable, later responses buffered, released in order after s_bready rises.
REQ-041 rst_n pulsed low with 3 entries done -> s_bvalid 0 immediately, occupancy 0, no stale B after reset release.
